// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: register address width
// and the stall sequencer state encodings.
package pipeline_hazard_controller_pkg;

    localparam int REG_ADDRESS_LEN = 4;

    typedef enum logic [1:0] {
        HZ_STATE_RUN   = 2'd0,
        HZ_STATE_WAIT  = 2'd1,
        HZ_STATE_ERROR = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect_logic.sv
// Combinational RAW detector: flags when an ID source register is produced by an
// instruction still in flight that the forwarding network cannot cover.
module hazard_detect_logic
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDRESS_LEN
) (
    input  logic [REG_ADDR_W-1:0] src1_addr,
    input  logic [REG_ADDR_W-1:0] src2_addr,
    input  logic                  two_src,
    input  logic                  ignore_hazard,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  forwarding_en,
    output logic                  raw_hit
);

    logic src1_match;
    logic src2_match;

    // With forwarding only a load in EXE is unresolvable; without it any pending write is.
    always_comb begin
        src1_match = 1'b0;
        src2_match = 1'b0;
        if (forwarding_en) begin
            src1_match = exe_mem_read & exe_wb_en & (exe_dest == src1_addr);
            src2_match = exe_mem_read & exe_wb_en & (exe_dest == src2_addr);
        end else begin
            src1_match = (exe_wb_en & (exe_dest == src1_addr)) |
                         (mem_wb_en & (mem_dest == src1_addr));
            src2_match = (exe_wb_en & (exe_dest == src2_addr)) |
                         (mem_wb_en & (mem_dest == src2_addr));
        end
        raw_hit = ~ignore_hazard & (src1_match | (two_src & src2_match));
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW bubbles, SRAM wait freezes,
// branch flushes, a memory watchdog and saturating stall counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDRESS_LEN,
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1_addr,
    input  logic [REG_ADDR_W-1:0] src2_addr,
    input  logic                  two_src,
    input  logic                  ignore_hazard,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  forwarding_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  sram_ready,
    output logic                  hazard,
    output logic                  freeze_if,
    output logic                  freeze_id,
    output logic                  freeze_exe,
    output logic                  freeze_mem,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  mem_timeout,
    output logic [PERF_W-1:0]     hazard_cycles,
    output logic [PERF_W-1:0]     mem_wait_cycles
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e        state;
    hz_state_e        state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             raw_hit;
    logic             mem_stall;
    logic             mem_freeze;
    logic             count_wait;

    hazard_detect_logic #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard_detect (
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .two_src      (two_src),
        .ignore_hazard(ignore_hazard),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .exe_mem_read (exe_mem_read),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .forwarding_en(forwarding_en),
        .raw_hit      (raw_hit)
    );

    assign mem_stall  = mem_req & ~sram_ready;
    assign mem_freeze = mem_stall | (state == HZ_STATE_ERROR);
    assign count_wait = mem_freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= HZ_STATE_RUN;
            wait_cnt        <= '0;
            hazard_cycles   <= '0;
            mem_wait_cycles <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (hazard && (hazard_cycles != '1))
                hazard_cycles <= hazard_cycles + PERF_W'(1);
            if (count_wait && (mem_wait_cycles != '1))
                mem_wait_cycles <= mem_wait_cycles + PERF_W'(1);
        end
    end

    // wait_cnt holds the number of stalled cycles seen so far in the current access.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            HZ_STATE_RUN: begin
                if (mem_stall) begin
                    state_next    = HZ_STATE_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end
            end
            HZ_STATE_WAIT: begin
                if (!mem_stall) begin
                    state_next    = HZ_STATE_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    state_next = HZ_STATE_ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            HZ_STATE_ERROR: begin
                state_next = HZ_STATE_ERROR;
            end
            default: begin
                state_next    = HZ_STATE_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // A memory freeze holds EXE, so branch/hazard inputs simply reappear once it lifts.
    always_comb begin
        hazard      = 1'b0;
        freeze_if   = 1'b0;
        freeze_id   = 1'b0;
        freeze_exe  = 1'b0;
        freeze_mem  = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            mem_timeout = (state == HZ_STATE_ERROR);
            if (mem_freeze) begin
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
                freeze_exe = 1'b1;
                freeze_mem = 1'b1;
            end else begin
                hazard    = raw_hit & ~branch_taken;
                freeze_if = raw_hit & ~branch_taken;
                flush_if  = branch_taken;
                flush_id  = branch_taken;
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Detects RAW data hazards on ID source registers and raises `hazard` to the ID stage, which inserts a bubble.
- Freezes every stage register while the MEM stage waits on a multi-cycle SRAM, and flushes IF/ID on a taken branch.
- Runs a memory-timeout watchdog and saturating stall performance counters.

Parameters:
- REG_ADDR_W, 4, register address width (matches `REG_ADDRESS_LEN`).
- MEM_TIMEOUT, 255, maximum consecutive SRAM wait cycles before the error state.
- PERF_W, 16, width of each performance counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- src1_addr  in  REG_ADDR_W  ID first source register.
- src2_addr  in  REG_ADDR_W  ID second source register.
- two_src  in  1  src2_addr is a real operand.
- ignore_hazard  in  1  ID instruction reads no registers (e.g. B).
- exe_wb_en  in  1  EXE-stage instruction writes back.
- exe_dest  in  REG_ADDR_W  EXE-stage destination register.
- exe_mem_read  in  1  EXE-stage instruction is a load.
- mem_wb_en  in  1  MEM-stage instruction writes back.
- mem_dest  in  REG_ADDR_W  MEM-stage destination register.
- forwarding_en  in  1  forwarding unit active.
- branch_taken  in  1  EXE-stage branch taken.
- mem_req  in  1  MEM-stage read or write in progress.
- sram_ready  in  1  SRAM completes the access this cycle.
- hazard  out  1  to ID stage: zero control signals (bubble).
- freeze_if  out  1  hold PC and IF register.
- freeze_id  out  1  hold ID register.
- freeze_exe  out  1  hold EXE register.
- freeze_mem  out  1  hold MEM register.
- flush_if  out  1  clear IF register.
- flush_id  out  1  clear ID register.
- mem_timeout  out  1  sticky watchdog error flag.
- hazard_cycles  out  PERF_W  count of bubble cycles.
- mem_wait_cycles  out  PERF_W  count of SRAM wait cycles.

Behaviour:
- Internal signals:
  - mem_stall = mem_req & ~sram_ready, combinational.
  - raw_hit = ~ignore_hazard & (m(src1_addr) | (two_src & m(src2_addr))).
  - With forwarding_en=1: m(r) = exe_mem_read & exe_wb_en & exe_dest==r (load-use only).
  - With forwarding_en=0: m(r) = (exe_wb_en & exe_dest==r) | (mem_wb_en & mem_dest==r).
- FSM states: RUN, WAIT, ERROR. Registered state; all outputs are combinational from state and inputs.
- RUN:
  - If mem_stall: go to WAIT and load wait_cnt=1.
  - All four freezes = mem_stall in this same cycle (zero-latency stall).
- WAIT:
  - All four freezes are asserted while mem_stall is true.
  - When sram_ready=1: freezes deassert this cycle and the FSM returns to RUN.
  - Otherwise wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT and still stalled: go to ERROR.
- ERROR:
  - All freezes are held at 1 and mem_timeout=1.
  - Exit only via rst.
- Hazard and flush priority:
  - When no memory freeze is active: flush_if = flush_id = branch_taken.
  - hazard = raw_hit & ~branch_taken. A branch flush beats the hazard because the ID instruction is wrong-path.
  - freeze_if = hazard. freeze_id/exe/mem stay 0 so the bubble advances.
- During a memory freeze:
  - flush_if, flush_id and hazard are forced to 0.
  - The EXE register is frozen, so branch_taken and the hazard inputs persist and take effect in the first unfrozen cycle. No pending flag is needed.
- Counters:
  - hazard_cycles increments on each cycle with hazard=1.
  - mem_wait_cycles increments on each cycle with mem_stall=1 or state==ERROR.
  - Both saturate at all-ones and never wrap.
- Reset:
  - rst=1 forces state=RUN, wait_cnt=0, mem_timeout=0 and both counters to 0.
  - Every 1-bit output is forced to 0 during the rst cycle.
  - A reset in the middle of WAIT or ERROR aborts the wait.
- Register r0 is a normal register. Any address match, including 4'hF, counts as a hazard.

Decomposition:
- `Defines.v` supplies REG_ADDRESS_LEN. Add HZ_STATE_RUN/WAIT/ERROR (2-bit) localparam encodings there.
- One combinational sub-module, hazard_detect_logic, computes raw_hit from the source, destination and forwarding inputs.
- The FSM, counters and priority logic stay in the top block.

Test Plan:
- Dependency with forwarding_en=0: src1=3 and exe_wb_en=1, exe_dest=3 -> hazard=1, freeze_if=1, other freezes 0, hazard_cycles=1 after one clock.
- Load-use with forwarding_en=1:
  - src2=5, two_src=1, exe_mem_read=1, exe_dest=5 -> hazard=1.
  - Same inputs with two_src=0 -> hazard=0.
  - Same inputs with ignore_hazard=1 -> hazard=0.
- branch_taken=1 together with a raw hit -> flush_if=flush_id=1 and hazard=0.
- mem_req=1, sram_ready=0 for 3 cycles then 1:
  - All freezes=1 for 3 cycles and 0 in the ready cycle.
  - State returns to RUN and mem_wait_cycles=3.
- branch_taken=1 during the SRAM wait:
  - flush_id=0 while frozen.
  - flush_id=1 in the cycle sram_ready=1.
- sram_ready held 0 for MEM_TIMEOUT+1 cycles:
  - Then mem_timeout=1 and freezes stay 1.
  - Assert rst for one cycle -> all outputs 0, counters 0, state RUN.
